typewriter_out: RTL

- Peripheral-side responder for G-15 slow output: the typewriter mechanism that the I/O control section drives.
- Accepts one 5-bit output character per strobe and translates it to ASCII for a host byte stream.
- Emulates mechanical print time in word-times, then returns the typewriter feedback pulse KEY_FB to the I/O control section.

---
 rtl/g15_io_pkg.sv | 23 ++
 rtl/g15_char_to_ascii.sv | 38 +++
 rtl/typewriter_out.sv | 127 ++++++++++++
 3 files changed

// File: rtl/g15_io_pkg.sv
// Shared G-15 I/O definitions: character codes and typewriter responder states.
package g15_io_pkg;

   typedef logic [4:0] g15_char_t;

   localparam g15_char_t CH_SPACE  = 5'b00000;
   localparam g15_char_t CH_MINUS  = 5'b00001;
   localparam g15_char_t CH_CR     = 5'b00010;
   localparam g15_char_t CH_TAB    = 5'b00011;
   localparam g15_char_t CH_STOP   = 5'b00100;
   localparam g15_char_t CH_RELOAD = 5'b00101;
   localparam g15_char_t CH_PERIOD = 5'b00110;
   localparam g15_char_t CH_WAIT   = 5'b00111;

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      EMIT_LF,
      PRINT,
      FEEDBACK
   } tw_state_e;

endpackage

// File: rtl/g15_char_to_ascii.sv
// Combinational translation of a G-15 output character code to its ASCII byte.
module g15_char_to_ascii
   import g15_io_pkg::*;
(
   input  g15_char_t   code,
   output logic [7:0]  ascii,
   output logic        printing,
   output logic        is_cr
);

   always_comb begin
      ascii    = 8'h3F;
      printing = 1'b1;
      is_cr    = 1'b0;
      if (code[4]) begin
         // hex digits A..F print as the letters u..z
         if (code[3:0] < 4'd10) ascii = 8'h30 + {4'h0, code[3:0]};
         else                   ascii = 8'h6B + {4'h0, code[3:0]};
      end else if (!code[3]) begin
         case (code)
            CH_SPACE:  ascii = 8'h20;
            CH_MINUS:  ascii = 8'h2D;
            CH_CR: begin
               ascii = 8'h0D;
               is_cr = 1'b1;
            end
            CH_TAB:    ascii = 8'h09;
            CH_PERIOD: ascii = 8'h2E;
            CH_STOP, CH_RELOAD, CH_WAIT: begin
               ascii    = 8'h00;
               printing = 1'b0;
            end
            default:   ascii = 8'h3F;
         endcase
      end
   end

endmodule

// File: rtl/typewriter_out.sv
// G-15 typewriter responder: ASCII byte stream out, print-time emulation, KEY_FB pulse back.
module typewriter_out
   import g15_io_pkg::*;
#(
   parameter int CHAR_WT = 270,
   parameter int CR_WT   = 810,
   parameter int FB_CLKS = 4
) (
   input  logic        CLOCK,
   input  logic        rst,
   input  logic        T0,
   input  logic        TYPE,
   input  logic        char_stb,
   input  logic [4:0]  char_code,
   output logic [7:0]  out_tdata,
   output logic        out_tvalid,
   input  logic        out_tready,
   output logic        KEY_FB,
   output logic        busy,
   output logic        overrun
);

   localparam int MAX_WT = (CHAR_WT > CR_WT) ? CHAR_WT : CR_WT;
   localparam int CNT_W  = $clog2(MAX_WT + 1);
   localparam int FB_W   = (FB_CLKS > 1) ? $clog2(FB_CLKS) : 1;

   tw_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FB_W-1:0]    fb_q, fb_d;
   logic [7:0]         data_q, data_d;
   logic               cr_q, cr_d;
   logic               ovr_q, ovr_d;

   logic [7:0]         map_ascii;
   logic               map_printing;
   logic               map_is_cr;

   g15_char_to_ascii u_map (
      .code     (char_code),
      .ascii    (map_ascii),
      .printing (map_printing),
      .is_cr    (map_is_cr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fb_d    = fb_q;
      data_d  = data_q;
      cr_d    = cr_q;
      ovr_d   = ovr_q;
      // any strobe outside IDLE is dropped, including on the FEEDBACK exit cycle
      if (char_stb && (state_q != IDLE)) ovr_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (char_stb && TYPE) begin
               cr_d = map_is_cr;
               if (map_printing) begin
                  data_d  = map_ascii;
                  state_d = EMIT;
               end else begin
                  fb_d    = '0;
                  state_d = FEEDBACK;
               end
            end
         end
         EMIT: begin
            if (out_tready) begin
               if (cr_q) begin
                  data_d  = 8'h0A;
                  state_d = EMIT_LF;
               end else begin
                  cnt_d   = CNT_W'(CHAR_WT);
                  state_d = PRINT;
               end
            end
         end
         EMIT_LF: begin
            if (out_tready) begin
               cnt_d   = CNT_W'(CR_WT);
               state_d = PRINT;
            end
         end
         PRINT: begin
            // a loaded count of zero finishes on the first tick, same as one
            if (T0) begin
               if (cnt_q <= CNT_W'(1)) begin
                  fb_d    = '0;
                  state_d = FEEDBACK;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         FEEDBACK: begin
            if (fb_q == FB_W'(FB_CLKS - 1)) state_d = IDLE;
            else                            fb_d    = fb_q + FB_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fb_q    <= '0;
         data_q  <= '0;
         cr_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fb_q    <= fb_d;
         data_q  <= data_d;
         cr_q    <= cr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_tdata  = data_q;
   assign out_tvalid = (state_q == EMIT) || (state_q == EMIT_LF);
   assign KEY_FB     = (state_q == FEEDBACK);
   assign busy       = (state_q != IDLE);
   assign overrun    = ovr_q;

endmodule
